div_unit: RTL and testbench



---
 rtl/div_unit_pkg.sv | 17 +
 rtl/div_unit_if.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 157 +++++++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encoding, widths and
// the fixed divide-by-zero result.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITERS  = DIV_DATA_W;

  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DIVZERO = 2'd2,
    ST_FIN     = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX-stage sequencer and the divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              flush;
  logic              stall_req;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output start, signed_div, operand_1, operand_2, flush,
    input  stall_req, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, operand_1, operand_2, flush,
    output stall_req, done, quotient, remainder
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference only when it does not go negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // shift in the next dividend bit and try the subtraction at W+1 bits
  always_comb begin
    rem_sh = {rem_i, quo_i[W-1]};
    trial  = rem_sh - {1'b0, div_i};
    if (!trial[W]) begin
      rem_o = trial[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      // a failed trial implies rem_sh < divisor, so it fits in W bits
      rem_o = rem_sh[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-cycle restoring divider for DIV/DIVU with pipeline stall.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | waiting for start; operands latched on acceptance
//  BUSY    | one quotient bit per cycle, MSB first, DATA_W cycles
//  DIVZERO | divisor was zero; load the fixed result
//  FIN     | done pulse, sign fix-up applied, results presented
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic              accept;
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_abs, op2_abs;
  logic [DATA_W-1:0] step_rem, step_quo;
  logic [DATA_W-1:0] fix_quo, fix_rem;

  div_step #(.W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (divisor_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // state and datapath registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // next-state: flush always returns to IDLE, FIN always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush)
          state_d = (bus.operand_2 == '0) ? ST_DIVZERO : ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.flush)               state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST)  state_d = ST_FIN;
      end
      ST_DIVZERO: state_d = bus.flush ? ST_IDLE : ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // operand magnitudes and the signed fix-up of the finished result
  always_comb begin
    accept  = (state_q == ST_IDLE) && bus.start && !bus.flush;
    op1_neg = bus.signed_div && bus.operand_1[DATA_W-1];
    op2_neg = bus.signed_div && bus.operand_2[DATA_W-1];
    op1_abs = op1_neg ? -bus.operand_1 : bus.operand_1;
    op2_abs = op2_neg ? -bus.operand_2 : bus.operand_2;
    fix_quo = q_neg_q ? -quo_q : quo_q;
    fix_rem = r_neg_q ? -rem_q : rem_q;
  end

  // datapath updates per state
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          rem_d = '0;
          if (bus.operand_2 == '0) begin
            // keep the raw dividend; it becomes the remainder unchanged
            quo_d     = bus.operand_1;
            divisor_d = '0;
            q_neg_d   = 1'b0;
            r_neg_d   = 1'b0;
          end else begin
            quo_d     = op1_abs;
            divisor_d = op2_abs;
            q_neg_d   = op1_neg ^ op2_neg;
            r_neg_d   = op1_neg;
          end
        end
      end
      ST_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DIVZERO: begin
        rem_d   = quo_q;
        quo_d   = DIV_ZERO_QUOT;
        q_neg_d = 1'b0;
        r_neg_d = 1'b0;
      end
      ST_FIN: begin
        quotient_d  = fix_quo;
        remainder_d = fix_rem;
      end
      default: ;
    endcase
    if (bus.flush) cnt_d = '0;
  end

  // outputs: results presented directly in FIN, held registers otherwise
  always_comb begin
    bus.done      = (state_q == ST_FIN);
    bus.stall_req = accept || (state_q == ST_BUSY) || (state_q == ST_DIVZERO);
    bus.quotient  = (state_q == ST_FIN) ? fix_quo : quotient_q;
    bus.remainder = (state_q == ST_FIN) ? fix_rem : remainder_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands against a plain-arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // reference: integer division truncating toward zero, fixed divide-by-zero result
  function automatic void ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // issue one divide at the next negedge (cycle N) and follow it to done
  task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int lat;
    ref_div(sd, a, b, eq, er);
    lat = (b == 0) ? 2 : 33;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.operand_1  = a;
    bus.operand_2  = b;
    #1;
    chk("stall_at_start", 32'(bus.stall_req), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        // start held with scrambled operands while busy must be ignored
        bus.signed_div = ~sd;
        bus.operand_1  = $urandom;
        bus.operand_2  = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      if (k < lat) begin
        chk("done_early", 32'(bus.done), 32'd0);
        chk("stall_busy", 32'(bus.stall_req), 32'd1);
      end else begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("stall_fin", 32'(bus.stall_req), 32'd0);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
      end
    end
    @(posedge clk);
    #1;
    chk("done_single", 32'(bus.done), 32'd0);
    chk("quotient_hold", bus.quotient, eq);
    chk("remainder_hold", bus.remainder, er);
  endtask

  logic [31:0] prev_q, prev_r, a, b;
  bit sd;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.operand_1  = '0;
    bus.operand_2  = '0;
    bus.flush      = 1'b0;
    #2;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", bus.quotient, 32'd0);
    chk("rst_remainder", bus.remainder, 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_div(1'b0, 32'h0000_1234, 32'd0);
    do_div(1'b1, 32'h8000_1234, 32'd0);

    // flush at N+10: no done, outputs unchanged, new start at N+11 completes
    prev_q = bus.quotient;
    prev_r = bus.remainder;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0;
    bus.operand_1 = 32'd5000; bus.operand_2 = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = (k == 10);
      chk("flush_no_done", 32'(bus.done), 32'd0);
    end
    chk("flush_stall", 32'(bus.stall_req), 32'd0);
    chk("flush_q_hold", bus.quotient, prev_q);
    chk("flush_r_hold", bus.remainder, prev_r);
    do_div(1'b1, 32'hFFFF_FC18, 32'd7);

    // async reset mid-BUSY
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0;
    bus.operand_1 = 32'd999; bus.operand_2 = 32'd10;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("amid_rst_done", 32'(bus.done), 32'd0);
    chk("amid_rst_q", bus.quotient, 32'd0);
    chk("amid_rst_r", bus.remainder, 32'd0);
    chk("amid_rst_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(1'b0, 32'd999, 32'd10);

    for (int i = 0; i < 40; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_div(sd, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
